// File: rtl/battle_pkg.sv
// battle_pkg: shared definitions for the battle screen blocks.
//   - battle state encodings (read by menu and phase blocks off the state bus)
//   - menu choice codes
package battle_pkg;

  // Raw encodings kept as plain constants for blocks that compare bit patterns.
  // MENU must stay 4'b0000: the menu block activates on a transition into 0000.
  localparam logic [3:0] ST_IDLE   = 4'b1010;
  localparam logic [3:0] ST_MENU   = 4'b0000;
  localparam logic [3:0] ST_ATTACK = 4'b0001;
  localparam logic [3:0] ST_ACT    = 4'b0010;
  localparam logic [3:0] ST_DODGE  = 4'b0011;
  localparam logic [3:0] ST_WIN    = 4'b0100;
  localparam logic [3:0] ST_LOSE   = 4'b0101;

  typedef enum logic [3:0] {
    IDLE   = ST_IDLE,
    MENU   = ST_MENU,
    ATTACK = ST_ATTACK,
    ACT    = ST_ACT,
    DODGE  = ST_DODGE,
    WIN    = ST_WIN,
    LOSE   = ST_LOSE
  } battle_state_t;

  localparam logic [1:0] CHOICE_ATTACK = 2'd0;
  localparam logic [1:0] CHOICE_ACT    = 2'd1;
  localparam logic [1:0] CHOICE_ITEM   = 2'd2;
  localparam logic [1:0] CHOICE_MERCY  = 2'd3;

endpackage

// File: rtl/battle_sequencer_timer.sv
// phase_timer: 32-bit phase cycle counter with a runtime limit.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count (state entry)
//   enable   : count this cycle
//   limit    : phase length in cycles
//   hit      : high while enabled and count == limit-1 (last cycle of phase)
// The owner always leaves the phase on hit, so the count never wraps.
module phase_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] limit,
  output logic        hit
);

  logic [31:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 32'd1;
    end
  end

  assign hit = enable && (count == limit - 32'd1);

endmodule

// File: rtl/battle_sequencer.sv
// battle_sequencer: turn scheduler for the battle screen.
//   MENU -> ATTACK / ACT / (mercy) -> DODGE -> MENU, with WIN / LOSE terminal.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start_in           level; rising edge starts a battle (from IDLE/WIN/LOSE)
//   menu_finished_in   1-cycle pulse, menu_choice_in / spare_ok_in valid with it
//   attack_done_in     1-cycle pulse, attack animation done
//   dialog_done_in     1-cycle pulse, act/item dialogue closed
//   dodge_done_in      1-cycle pulse, bullet pattern ended early
//   player_hp_in       player HP (0 in DODGE -> LOSE)
//   enemy_hp_in        enemy HP (0 at attack end -> WIN)
//   state_out          registered battle state (battle_pkg encoding)
//   *_start_out        1-cycle pulses in the first cycle of ATTACK/ACT/DODGE
//   win_out, lose_out  levels, high in WIN / LOSE
//   turn_out           completed DODGE phases, saturating at 255
module battle_sequencer
  import battle_pkg::*;
#(
  parameter int unsigned DODGE_CYCLES  = 32500000,
  parameter int unsigned PHASE_TIMEOUT = 65000000,
  parameter int unsigned HP_W          = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic            menu_finished_in,
  input  logic [1:0]      menu_choice_in,
  input  logic            attack_done_in,
  input  logic            dialog_done_in,
  input  logic            dodge_done_in,
  input  logic            spare_ok_in,
  input  logic [HP_W-1:0] player_hp_in,
  input  logic [HP_W-1:0] enemy_hp_in,
  output logic [3:0]      state_out,
  output logic            attack_start_out,
  output logic            dialog_start_out,
  output logic            dodge_start_out,
  output logic            win_out,
  output logic            lose_out,
  output logic [7:0]      turn_out
);

  battle_state_t state, next_state;
  logic          start_prev;
  logic          start_edge;
  logic          in_phase;
  logic          timer_hit;
  logic [31:0]   timer_limit;

  assign start_edge  = start_in && !start_prev;
  assign in_phase    = (state == ATTACK) || (state == ACT) || (state == DODGE);
  assign timer_limit = (state == DODGE) ? 32'(DODGE_CYCLES) : 32'(PHASE_TIMEOUT);

  phase_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (next_state != state),
    .enable (in_phase),
    .limit  (timer_limit),
    .hit    (timer_hit)
  );

  // NOTE: next_state is defaulted before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start_edge) next_state = MENU;
      MENU: begin
        if (menu_finished_in) begin
          unique case (menu_choice_in)
            CHOICE_ATTACK: next_state = ATTACK;
            CHOICE_ACT,
            CHOICE_ITEM:   next_state = ACT;
            CHOICE_MERCY:  next_state = spare_ok_in ? WIN : DODGE;
          endcase
        end
      end
      // attack_done beats the timeout when both land on the same cycle.
      ATTACK: begin
        if (attack_done_in)  next_state = (enemy_hp_in == '0) ? WIN : DODGE;
        else if (timer_hit)  next_state = DODGE;
      end
      ACT: if (dialog_done_in || timer_hit) next_state = DODGE;
      // A dead player beats both early end and timeout.
      DODGE: begin
        if (player_hp_in == '0)              next_state = LOSE;
        else if (dodge_done_in || timer_hit) next_state = MENU;
      end
      WIN, LOSE: if (start_edge) next_state = MENU;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      start_prev       <= 1'b0;
      attack_start_out <= 1'b0;
      dialog_start_out <= 1'b0;
      dodge_start_out  <= 1'b0;
      win_out          <= 1'b0;
      lose_out         <= 1'b0;
      turn_out         <= 8'd0;
    end else begin
      state            <= next_state;
      start_prev       <= start_in;
      // Pulses and levels are registered from next_state so they line up
      // with the first cycle the new state is visible.
      attack_start_out <= (next_state == ATTACK) && (state != ATTACK);
      dialog_start_out <= (next_state == ACT)    && (state != ACT);
      dodge_start_out  <= (next_state == DODGE)  && (state != DODGE);
      win_out          <= (next_state == WIN);
      lose_out         <= (next_state == LOSE);
      if (state == DODGE && next_state == MENU) begin
        if (turn_out != 8'hFF) turn_out <= turn_out + 8'd1;
      end else if ((state == WIN || state == LOSE) && next_state == MENU) begin
        turn_out <= 8'd0;
      end
    end
  end

  assign state_out = state;

endmodule
